sram_port_arbiter: RTL and testbench

- Shares one single-port sram-like memory channel between the instruction-fetch requester and the data-access requester of the pipelined CPU.
- Sits between the fetch/memory stages and the bus bridge.
- Picks one request per cycle and tracks outstanding transactions in an ID FIFO so in-order responses return to the right requester.
- Has an anti-starvation counter so fetch is never locked out by back-to-back data traffic.

---
 rtl/sram_port_arbiter.sv | 110 +++++++++++
 tb/tb_sram_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one in-order sram-like channel between fetch and data requesters.
// Source IDs of accepted requests are queued so each response is steered back to its owner.
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               inst_req,
  input  logic [31:0]                        inst_addr,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [31:0]                        inst_rdata,
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [3:0]                         data_wstrb,
  input  logic [31:0]                        data_addr,
  input  logic [31:0]                        data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [31:0]                        data_rdata,
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [3:0]                         mem_wstrb,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic                               mem_addr_ok,
  input  logic                               mem_data_ok,
  input  logic [31:0]                        mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic          SRC_INST   = 1'b0;
  localparam logic          SRC_DATA   = 1'b1;

  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       err_q, err_d;

  logic full, inst_prio, sel_data, push, pop, head, inst_acc;

  // Outputs are forced low while resetn is asserted, so nothing leaks from the input mux.
  assign full      = (count_q == CNT_FULL);
  assign inst_prio = inst_req && (starve_q >= STARVE_MAX);
  assign sel_data  = data_req && !inst_prio;
  assign mem_req   = resetn && (inst_req || data_req) && !full;
  assign push      = mem_req && mem_addr_ok;
  assign pop       = resetn && mem_data_ok && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign inst_acc  = push && !sel_data;

  assign mem_wr    = mem_req && sel_data && data_wr;
  assign mem_wstrb = (mem_req && sel_data) ? data_wstrb : 4'h0;
  assign mem_wdata = (mem_req && sel_data) ? data_wdata : 32'h0;
  assign mem_addr  = !mem_req ? 32'h0 : (sel_data ? data_addr : inst_addr);

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = push && sel_data;
  assign inst_data_ok = pop && (head == SRC_INST);
  assign data_data_ok = pop && (head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = count_q;
  assign err          = err_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    starve_d = '0;
    if (inst_req && !inst_acc)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    err_d = err_q || (mem_data_ok && (count_q == '0));
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // NOTE: ID storage is not reset; an entry is only read after it was written, as tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= sel_data;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; a queue of expected response owners is filled on
// every predicted accept and drained as the bench returns memory responses.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  outstanding;
  logic        err;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];   // 0 = inst, 1 = data

  sram_port_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Expects mem_data_ok/mem_rdata already driven and settled.
  task automatic check_resp(input logic [31:0] rd);
    bit src;
    if (exp_q.size() == 0) begin
      check("resp_unexpected", 32'd1, 32'd0);
    end else begin
      src = exp_q.pop_front();
      check("inst_data_ok", inst_data_ok, {31'd0, !src});
      check("data_data_ok", data_data_ok, {31'd0, src});
      if (src) check("data_rdata", data_rdata, rd);
      else     check("inst_rdata", inst_rdata, rd);
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    @(negedge clk);
    idle();
    mem_data_ok = 1; mem_rdata = rd;
    #1;
    check_resp(rd);
  endtask

  initial begin
    idle();
    resetn = 0;
    inst_req = 1;
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    @(negedge clk); idle(); resetn = 1;

    // Lone fetch
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h1C00_0000);
    check("f_mem_wr", mem_wr, 0);
    check("f_mem_wstrb", mem_wstrb, 0);
    check("f_inst_addr_ok", inst_addr_ok, 1);
    check("f_data_addr_ok", data_addr_ok, 0);
    exp_q.push_back(0);
    @(negedge clk); idle(); #1;
    check("f_outstanding1", outstanding, 1);
    respond(32'h0280_0000);
    @(negedge clk); idle(); #1;
    check("f_outstanding0", outstanding, 0);

    // Simultaneous requests: data first, then inst
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_addr = 32'h0000_0100; mem_addr_ok = 1;
    #1;
    check("s_data_addr_ok", data_addr_ok, 1);
    check("s_inst_addr_ok", inst_addr_ok, 0);
    check("s_mem_addr", mem_addr, 32'h0000_0100);
    exp_q.push_back(1);
    @(negedge clk); data_req = 0; #1;
    check("s_inst_addr_ok2", inst_addr_ok, 1);
    check("s_mem_addr2", mem_addr, 32'h1C00_0004);
    exp_q.push_back(0);
    @(negedge clk); idle(); #1;
    check("s_outstanding", outstanding, 2);
    respond(32'hAAAA_0001);
    respond(32'hBBBB_0002);
    @(negedge clk); idle(); #1;
    check("s_outstanding0", outstanding, 0);

    // Starvation: inst wins after 8 stalled cycles, then counter restarts
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle();
      inst_req = 1; inst_addr = 32'h1C00_1000;
      data_req = 1; data_addr = 32'h0000_2000 + 32'(k);
      mem_addr_ok = 1;
      mem_data_ok = (k != 0); mem_rdata = 32'h5000_0000 + 32'(k);
      #1;
      if (k != 0) check_resp(mem_rdata);
      check($sformatf("st_inst_ok_%0d", k), inst_addr_ok, {31'd0, k == 8});
      check($sformatf("st_data_ok_%0d", k), data_addr_ok, {31'd0, k != 8});
      check($sformatf("st_addr_%0d", k), mem_addr,
            (k == 8) ? 32'h1C00_1000 : 32'h0000_2000 + 32'(k));
      exp_q.push_back(k != 8);
    end
    respond(32'h5000_00FF);
    @(negedge clk); idle(); #1;
    check("st_outstanding0", outstanding, 0);
    check("st_err", err, 0);

    // Full
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      data_req = 1; data_addr = 32'h0000_0300 + 32'(4 * i); mem_addr_ok = 1;
      #1;
      check($sformatf("full_acc_%0d", i), data_addr_ok, 1);
      exp_q.push_back(1);
    end
    @(negedge clk); inst_req = 1; #1;
    check("full_outstanding", outstanding, 4);
    check("full_mem_req", mem_req, 0);
    check("full_data_addr_ok", data_addr_ok, 0);
    check("full_inst_addr_ok", inst_addr_ok, 0);
    @(negedge clk); inst_req = 0; mem_data_ok = 1; mem_rdata = 32'hC0DE_0000; #1;
    check_resp(32'hC0DE_0000);
    check("full_pop_mem_req", mem_req, 0);
    @(negedge clk); mem_data_ok = 0; #1;
    check("full_outstanding3", outstanding, 3);
    check("full_mem_req_back", mem_req, 1);
    check("full_reaccept", data_addr_ok, 1);
    exp_q.push_back(1);
    for (int i = 0; i < 4; i++) respond(32'hC0DE_0001 + 32'(i));
    @(negedge clk); idle(); #1;
    check("full_drained", outstanding, 0);

    // Write pass-through
    @(negedge clk);
    data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'hDEAD_BEEF;
    data_addr = 32'h0000_0800; mem_addr_ok = 1;
    #1;
    check("w_mem_wr", mem_wr, 1);
    check("w_mem_wstrb", mem_wstrb, 4'h3);
    check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("w_mem_addr", mem_addr, 32'h0000_0800);
    check("w_data_addr_ok", data_addr_ok, 1);
    exp_q.push_back(1);
    @(negedge clk); idle();
    respond(32'h0);
    @(negedge clk); idle(); #1;
    check("w_outstanding0", outstanding, 0);

    // Spurious response
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h1234_5678; #1;
    check("sp_inst_data_ok", inst_data_ok, 0);
    check("sp_data_data_ok", data_data_ok, 0);
    @(negedge clk); idle(); #1;
    check("sp_err", err, 1);

    // Async reset with two outstanding
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_2000; mem_addr_ok = 1;
    @(negedge clk); idle(); data_req = 1; data_addr = 32'h0000_0900; mem_addr_ok = 1;
    @(negedge clk); idle(); #1;
    check("r_outstanding2", outstanding, 2);
    check("r_err_before", err, 1);
    #2 resetn = 0;
    #1;
    check("r_async_outstanding", outstanding, 0);
    check("r_async_err", err, 0);
    @(negedge clk); resetn = 1;
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD; #1;
    check("r_late_inst_ok", inst_data_ok, 0);
    check("r_late_data_ok", data_data_ok, 0);
    @(negedge clk); idle(); #1;
    check("r_late_err", err, 1);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
